// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the memory-access stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        LB  = 4'd1,
        LBU = 4'd2,
        LH  = 4'd3,
        LHU = 4'd4,
        LW  = 4'd5,
        SB  = 4'd6,
        SH  = 4'd7,
        SW  = 4'd8
    } lsu_op_t;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_BUSY = 2'd1;
    localparam lsu_state_t ST_DONE = 2'd2;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= LB) && (op <= SW);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for big-endian loads and stores, plus alignment check.
// Latency: purely combinational.
// Backpressure: none; outputs track inputs.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  rd_b;
    logic [15:0] rd_h;

    // Byte 0 lives in the most significant lane.
    assign rd_b = 8'(rdata >> {~addr, 3'b000});
    assign rd_h = 16'(rdata >> {~addr[1], 4'b0000});

    always_comb begin
        sel        = 4'b0000;
        wdata      = rt;
        load_data  = ZeroWord;
        misaligned = 1'b0;
        case (op)
            LB, LBU, SB: begin
                sel       = 4'b1000 >> addr;
                wdata     = {4{rt[7:0]}};
                load_data = (op == LB) ? {{24{rd_b[7]}}, rd_b} : {24'b0, rd_b};
            end
            LH, LHU, SH: begin
                misaligned = addr[0];
                sel        = addr[1] ? 4'b0011 : 4'b1100;
                wdata      = {2{rt[15:0]}};
                load_data  = (op == LH) ? {{16{rd_h[15]}}, rd_h} : {16'b0, rd_h};
            end
            LW, SW: begin
                misaligned = |addr;
                sel        = 4'b1111;
                load_data  = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: ALU results pass through, loads/stores run one req/ack bus cycle.
// Latency: pass-through 0 cycles; memory op 1 issue cycle + bus wait, result on the ack cycle.
// Backpressure: stallreq holds the pipeline until ack/timeout; stall_i at ack parks the result in DONE.
module mem_lsu
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [3:0]            ex_memop,
    input  logic [ADDR_W-1:0]     ex_memaddr,
    input  logic [DATA_W-1:0]     ex_memdata,
    input  logic                  stall_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  stallreq,
    output logic                  exc_align,
    output logic                  exc_bus,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack
);

    localparam int               CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DATA_W-1:0]     wdata;
    } wb_t;

    lsu_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [3:0]            op_q;
    logic [1:0]            a_q;
    logic [REG_ADDR_W-1:0] wd_q;
    logic                  wreg_q;
    wb_t                   res_q;
    wb_t                   wb;

    logic        idle;
    logic [3:0]  al_op;
    logic [1:0]  al_addr;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_mis;
    logic        start;
    logic        finish;

    // While busy the ex_mem inputs may be anything, so lane logic runs off the latched op.
    assign idle    = (state == ST_IDLE);
    assign al_op   = idle ? ex_memop : op_q;
    assign al_addr = idle ? ex_memaddr[1:0] : a_q;

    lsu_align u_align (
        .op         (al_op),
        .addr       (al_addr),
        .rt         (ex_memdata),
        .rdata      (bus_rdata),
        .sel        (al_sel),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_mis)
    );

    assign start  = idle && is_mem_op(ex_memop) && !al_mis;
    assign finish = (state == ST_BUSY) && (bus_ack || (cnt == TO_MAX));

    always_comb begin
        wb.wd     = ex_wd;
        wb.wreg   = ex_wreg;
        wb.wdata  = ex_wdata;
        stallreq  = 1'b0;
        exc_align = 1'b0;
        exc_bus   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_mem_op(ex_memop)) begin
                    wb.wreg = WriteDisable;
                    if (al_mis) exc_align = 1'b1;
                    else        stallreq  = 1'b1;
                end
            end
            ST_BUSY: begin
                wb.wd    = wd_q;
                wb.wreg  = WriteDisable;
                wb.wdata = '0;
                if (bus_ack) begin
                    if (!is_store_op(op_q)) begin
                        wb.wreg  = wreg_q;
                        wb.wdata = al_load;
                    end
                end else if (cnt == TO_MAX) begin
                    exc_bus = 1'b1;
                end else begin
                    stallreq = 1'b1;
                end
            end
            ST_DONE: wb = res_q;
            default: ;
        endcase
    end

    assign mem_wd    = wb.wd;
    assign mem_wreg  = wb.wreg;
    assign mem_wdata = wb.wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_sel   <= 4'b0000;
            bus_wdata <= '0;
            op_q      <= NOP;
            a_q       <= 2'b00;
            wd_q      <= REG_ADDR_W'(NOPRegAddr);
            wreg_q    <= WriteDisable;
            res_q     <= '{wd: REG_ADDR_W'(NOPRegAddr), wreg: WriteDisable, wdata: '0};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus_req   <= 1'b1;
                        bus_we    <= is_store_op(ex_memop);
                        bus_addr  <= {ex_memaddr[ADDR_W-1:2], 2'b00};
                        bus_sel   <= al_sel;
                        bus_wdata <= al_wdata;
                        cnt       <= '0;
                        op_q      <= ex_memop;
                        a_q       <= ex_memaddr[1:0];
                        wd_q      <= ex_wd;
                        wreg_q    <= ex_wreg;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        bus_req <= 1'b0;
                        if (stall_i) begin
                            res_q <= wb;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!stall_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: vector table, directed corner sequences and random transactions
// checked against a spec-level lane/extension model.
module tb_mem_lsu;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_memaddr;
    logic [31:0] ex_memdata;
    logic        stall_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq;
    logic        exc_align;
    logic        exc_bus;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32), .DATA_W(32), .REG_ADDR_W(5), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_memop(ex_memop),
        .ex_memaddr(ex_memaddr), .ex_memdata(ex_memdata), .stall_i(stall_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .stallreq(stallreq), .exc_align(exc_align), .exc_bus(exc_bus),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Reference model: access size, lane mask and data placement from plain arithmetic.
    function automatic int op_size(input logic [3:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
        int sz  = op_size(op);
        int idx = int'(addr[1:0]);
        return 4'(((1 << sz) - 1) << (4 - sz - idx));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] rt);
        int sz = op_size(op);
        if (sz == 1) return (rt & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (rt & 32'hFFFF) * 32'h0001_0001;
        return rt;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int          sz   = op_size(op);
        int          idx  = int'(addr[1:0]);
        logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        logic [31:0] v    = (rdata >> (8 * (4 - sz - idx))) & mask;
        if (((op == LB) || (op == LH)) && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rdata, input logic [4:0] wd, input logic wreg,
                          input int ack_dly, input int hold, input logic [31:0] alu);
        int          sz = op_size(op);
        int          stalls;
        logic [31:0] exp_res;
        logic        exp_wreg;
        ex_wd = wd; ex_wreg = wreg; ex_wdata = alu;
        ex_memop = op; ex_memaddr = addr; ex_memdata = rt;
        stall_i = 1'b0; bus_ack = 1'b0;
        mid();
        if (sz == 0) begin
            chk("pass_wdata", mem_wdata, alu);
            chk("pass_wd", mem_wd, wd);
            chk("pass_wreg", mem_wreg, wreg);
            chk("pass_stall", stallreq, 0);
            step();
            chk("pass_no_req", bus_req, 0);
            return;
        end
        if ((int'(addr[1:0]) % sz) != 0) begin
            chk("mis_align", exc_align, 1);
            chk("mis_stall", stallreq, 0);
            chk("mis_wreg", mem_wreg, 0);
            step();
            chk("mis_no_req", bus_req, 0);
            ex_memop = NOP;
            return;
        end
        chk("issue_stall", stallreq, 1);
        stalls = 1;
        step();
        chk("bus_req", bus_req, 1);
        chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
        chk("bus_sel", bus_sel, m_sel(op, addr));
        chk("bus_we", bus_we, op_is_store(op));
        if (op_is_store(op)) chk("bus_wdata", bus_wdata, m_wdata(op, rt));
        for (int d = 0; d < ack_dly; d++) begin
            mid();
            if (stallreq) stalls++;
            chk("busy_req_held", bus_req, 1);
            chk("busy_addr_held", bus_addr, addr & 32'hFFFF_FFFC);
            step();
        end
        bus_ack = 1'b1; bus_rdata = rdata; stall_i = (hold > 0);
        exp_wreg = op_is_store(op) ? 1'b0 : wreg;
        exp_res  = m_load(op, addr, rdata);
        mid();
        chk("stall_cycles", stalls, 1 + ack_dly);
        chk("ack_stall", stallreq, 0);
        chk("ack_wreg", mem_wreg, exp_wreg);
        if (!op_is_store(op)) begin
            chk("ack_wdata", mem_wdata, exp_res);
            chk("ack_wd", mem_wd, wd);
        end
        step();
        bus_ack = 1'b0; bus_rdata = $urandom;
        chk("req_drop", bus_req, 0);
        for (int h = 0; h < hold; h++) begin
            if (h == hold - 1) stall_i = 1'b0;
            mid();
            chk("done_wreg", mem_wreg, exp_wreg);
            if (!op_is_store(op)) chk("done_wdata", mem_wdata, exp_res);
            chk("done_stall", stallreq, 0);
            chk("done_no_reissue", bus_req, 0);
            step();
        end
        ex_memop = NOP; stall_i = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] alu;
        logic [4:0]  wd;
        logic        wreg;
        bit          cmp_wb;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic        e_align;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{NOP, 32'h0,    32'h0000_1234, 5'd3,  1'b1, 1'b1, 5'd3,  1'b1, 32'h0000_1234, 1'b0, 1'b0};
        vecs[1] = '{NOP, 32'h7,    32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[2] = '{LW,  32'h3,    32'h55,        5'd4,  1'b1, 1'b1, 5'd4,  1'b0, 32'h0,         1'b0, 1'b1};
        vecs[3] = '{LH,  32'h1001, 32'h0,         5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 1'b1};
        vecs[4] = '{LHU, 32'h3,    32'h0,         5'd6,  1'b1, 1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 1'b1};
        vecs[5] = '{SH,  32'h5,    32'h0,         5'd7,  1'b0, 1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 1'b1};
        vecs[6] = '{SW,  32'h2,    32'h0,         5'd8,  1'b0, 1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 1'b1};
        vecs[7] = '{LW,  32'h1,    32'h0,         5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 1'b1};
        vecs[8] = '{LB,  32'h3,    32'h0,         5'd10, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,         1'b1, 1'b0};
        vecs[2].e_wdata = 32'h55;
        vecs[2].cmp_wb  = 1'b0;

        rst = 1'b0; ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_memop = NOP;
        ex_memaddr = '0; ex_memdata = '0; stall_i = 1'b0; bus_rdata = '0; bus_ack = 1'b0;

        step(); step();
        mid();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_sel", bus_sel, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_mem_wd", mem_wd, NOPRegAddr);
        chk("rst_mem_wreg", mem_wreg, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_stallreq", stallreq, 0);
        chk("rst_exc_align", exc_align, 0);
        chk("rst_exc_bus", exc_bus, 0);
        step();
        rst = 1'b1;

        foreach (vecs[i]) begin
            ex_memop = vecs[i].op; ex_memaddr = vecs[i].addr; ex_wdata = vecs[i].alu;
            ex_wd = vecs[i].wd; ex_wreg = vecs[i].wreg;
            mid();
            chk($sformatf("vec%0d_stall", i), stallreq, vecs[i].e_stall);
            chk($sformatf("vec%0d_align", i), exc_align, vecs[i].e_align);
            if (vecs[i].e_align) chk($sformatf("vec%0d_wreg", i), mem_wreg, 0);
            if (vecs[i].cmp_wb) begin
                chk($sformatf("vec%0d_wd", i), mem_wd, vecs[i].e_wd);
                chk($sformatf("vec%0d_wreg", i), mem_wreg, vecs[i].e_wreg);
                chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            #1 ex_memop = NOP;
            step();
            chk($sformatf("vec%0d_no_req", i), bus_req, 0);
        end

        do_txn(LB,  32'h101, 32'h0,         32'h11F3_2244, 5'd7,  1'b1, 2, 0, 32'h0);
        do_txn(LBU, 32'h101, 32'h0,         32'h11F3_2244, 5'd8,  1'b1, 2, 0, 32'h0);
        do_txn(SH,  32'h202, 32'hAAAA_5678, 32'h0,         5'd9,  1'b0, 1, 0, 32'h0);
        do_txn(LW,  32'h300, 32'h0,         32'hDEAD_BEEF, 5'd11, 1'b1, 1, 4, 32'h0);
        mid();
        chk("hold_after_no_req", bus_req, 0);
        step();

        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [31:0] addr;
            int          sz;
            op   = 4'($urandom_range(0, 8));
            addr = $urandom;
            sz   = op_size(op);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2) addr[0] = 1'b0;
                if (sz == 4) addr[1:0] = 2'b00;
            end
            do_txn(op, addr, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        begin
            int reqs = 0;
            bit seen = 1'b0;
            ex_memop = LW; ex_memaddr = 32'h400; ex_wd = 5'd12; ex_wreg = 1'b1;
            mid();
            step();
            for (int c = 0; c < 20 && !seen; c++) begin
                mid();
                if (bus_req) reqs++;
                if (exc_bus) begin
                    seen = 1'b1;
                    chk("to_stall", stallreq, 0);
                    chk("to_wreg", mem_wreg, 0);
                end else begin
                    step();
                end
            end
            chk("to_seen", seen, 1);
            chk("to_req_cycles", reqs, 5);
            step();
            ex_memop = NOP; ex_wdata = 32'hCAFE_F00D;
            chk("to_req_drop", bus_req, 0);
            mid();
            chk("to_exc_pulse", exc_bus, 0);
            step();
            bus_ack = 1'b1;
            mid();
            chk("late_ack_stall", stallreq, 0);
            chk("late_ack_wdata", mem_wdata, 32'hCAFE_F00D);
            chk("late_ack_exc", exc_bus, 0);
            step();
            bus_ack = 1'b0;
            chk("late_ack_no_req", bus_req, 0);
        end

        ex_memop = SW; ex_memaddr = 32'h504; ex_memdata = 32'h1234_5678;
        mid();
        step();
        chk("rstb_req_on", bus_req, 1);
        rst = 1'b0; ex_memop = NOP;
        step();
        chk("rstb_req", bus_req, 0);
        chk("rstb_we", bus_we, 0);
        chk("rstb_addr", bus_addr, 0);
        chk("rstb_sel", bus_sel, 0);
        chk("rstb_wdata", bus_wdata, 0);
        mid();
        chk("rstb_stall", stallreq, 0);
        chk("rstb_exc", exc_bus, 0);
        rst = 1'b1;
        step();
        chk("rstb_idle_req", bus_req, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage of the 5-stage CPU. Sits between the ex_mem and mem_wb pipeline registers.
- Non-memory instructions pass through combinationally.
- Loads and stores run a registered bus transaction with req/ack, with stall and timeout handling.
- Produces the write-back triple (wd, wreg, wdata) that mem_wb registers.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 32, register/bus data width; fixed at 32 for byte-lane logic.
- REG_ADDR_W, 5, register-file address width.
- TIMEOUT, 255, maximum cycles in BUSY without bus_ack before a bus error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge).
- ex_wd  in  REG_ADDR_W  destination register from ex_mem.
- ex_wreg  in  1  write-enable from ex_mem.
- ex_wdata  in  DATA_W  ALU result from ex_mem.
- ex_memop  in  4  memory opcode (lsu_op_t).
- ex_memaddr  in  ADDR_W  effective address.
- ex_memdata  in  DATA_W  store data (rt).
- stall_i  in  1  pipeline hold from the stall controller (the mem_wb stall input).
- mem_wd  out  REG_ADDR_W  to mem_wb.
- mem_wreg  out  1  to mem_wb.
- mem_wdata  out  DATA_W  to mem_wb.
- stallreq  out  1  request to hold the whole pipeline.
- exc_align  out  1  misaligned-access pulse.
- exc_bus  out  1  bus-timeout pulse.
- bus_req  out  1  registered request.
- bus_we  out  1  registered write enable.
- bus_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0).
- bus_sel  out  4  byte-lane enables.
- bus_wdata  out  DATA_W  lane-replicated store data.
- bus_rdata  in  DATA_W  read data.
- bus_ack  in  1  single-cycle completion.

Behaviour:
- Reset (rst==0): state=IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, timeout counter=0.
  - mem_wd=NOPRegAddr, mem_wreg=0, mem_wdata=0, stallreq=0, exc_*=0.
- Reset mid-BUSY aborts the transaction; bus_req drops on that same edge.
- Opcodes: NOP, LB, LBU, LH, LHU, LW, SB, SH, SW.
- Alignment:
  - Halfword requires addr[0]==0; word requires addr[1:0]==0.
  - Misaligned op: no bus cycle, mem_wreg=0, exc_align=1 for that cycle, no stall.
- IDLE, op is NOP: mem_* = ex_* combinationally; stallreq=0.
- IDLE, aligned mem op:
  - stallreq=1 combinationally.
  - At the edge: latch bus_addr, bus_we, bus_sel and bus_wdata; load wd/wreg; clear counter; go to BUSY.
- Byte lanes, big-endian:
  - Byte: addr 0→sel 1000, 1→0100, 2→0010, 3→0001.
  - Halfword: addr 0→1100, 2→0011.
  - Word: 1111.
- Store data replication: SB puts {4{rt[7:0]}} on bus_wdata; SH puts {2{rt[15:0]}}.
- BUSY:
  - bus_req=1; counter increments each cycle.
  - stallreq=1 until the ack cycle.
- BUSY, bus_ack=1:
  - Loads: select the lane, then sign- or zero-extend into mem_wdata combinationally that same cycle.
  - Stores: mem_wreg=0.
  - stallreq=0 this cycle.
  - bus_req drops at the edge.
  - If stall_i=0, next state is IDLE. If stall_i=1, capture the result and go to DONE.
- DONE:
  - Outputs come from the captured result; stallreq=0; no new bus cycle.
  - Return to IDLE on the first cycle with stall_i=0.
  - This prevents re-issue while the instruction is held in ex_mem.
- BUSY, counter==TIMEOUT with no ack:
  - Drop bus_req; exc_bus=1 for one cycle; mem_wreg=0; stallreq=0.
  - Next state is IDLE, or DONE if stall_i=1.
- A late bus_ack received in IDLE or DONE is ignored.
- bus_* outputs stay stable throughout BUSY.

Decomposition:
- Shared package cpu_pkg:
  - lsu_op_t enum.
  - lsu_state_t (IDLE, BUSY, DONE).
  - Constants NOPRegAddr, ZeroWord, WriteEnable/Disable.
- Sub-module lsu_align (combinational):
  - Inputs: op, addr[1:0], rt, rdata.
  - Outputs: sel, wdata, load result, misaligned.
- mem_lsu holds the FSM, the timeout counter and the result capture.

Test Plan:
- Reset and pass-through:
  - rst=0 for 2 cycles → all outputs zero, mem_wd=NOPRegAddr.
  - Then ALU op wd=3, wdata=0x1234 → mem_wdata=0x1234 same cycle, stallreq=0.
- LB, addr=0x101, bus_rdata=0x11F32244, ack 2 cycles after req:
  - bus_sel=0100, bus_addr=0x100.
  - stallreq high for 3 cycles.
  - mem_wdata=0xFFFFFFF3; LBU gives 0x000000F3.
- SH, addr=0x202, rt=0xAAAA5678:
  - bus_we=1, sel=0011, bus_wdata=0x56785678.
  - After ack: mem_wreg=0.
- LW, addr=0x3 → exc_align=1 one cycle, bus_req never asserted, mem_wreg=0.
- LW with stall_i=1 at ack, held 3 more cycles:
  - Exactly one bus_req pulse train.
  - mem_wdata holds 0xDEADBEEF until stall_i falls.
- LW with no ack, TIMEOUT=4:
  - bus_req high 5 cycles, then exc_bus=1, stallreq=0.
  - Late ack ignored.
  - Second run: rst=0 mid-BUSY → bus_req=0 next edge.
